// File: rtl/c1541_head_ctrl.sv
// Head positioning, side select and track-flush request control for the 1541/1571 SD path.
// Also times the write-protect flicker seen by the VIA after a disk image change.
module c1541_head_ctrl #(
  parameter int HT_W       = 7,
  parameter int HT_MIN     = 1,
  parameter int HT_MAX     = 80,
  parameter int HT_INIT    = 36,
  parameter int SIDES      = 1,
  parameter int SETTLE_CYC = 0,
  parameter int CHG_CYC    = 15000000
) (
  input  logic            clk32,
  input  logic            reset_n,
  input  logic            mtr,
  input  logic [1:0]      stp,
  input  logic            side,
  input  logic            act,
  input  logic            buff_we,
  input  logic            disk_change,
  input  logic            disk_readonly,
  output logic [HT_W-1:0] half_track,
  output logic [5:0]      track,
  output logic            head_side,
  output logic            tr00_sense_n,
  output logic            wps_n,
  output logic            track_settled,
  output logic            save_req,
  output logic [5:0]      save_track,
  output logic            save_side,
  input  logic            save_ack,
  output logic            save_overrun
);

  localparam int SET_W = (SETTLE_CYC < 2) ? 1 : $clog2(SETTLE_CYC + 1);
  localparam int CHG_W = (CHG_CYC < 2) ? 1 : $clog2(CHG_CYC + 1);
  localparam logic [HT_W-1:0] HT_MIN_V  = HT_W'(HT_MIN);
  localparam logic [HT_W-1:0] HT_MAX_V  = HT_W'(HT_MAX);
  localparam logic [HT_W-1:0] HT_INIT_V = HT_W'(HT_INIT);

  // Phase sequence of the stepper: up walks 0->2->1->3->0, down walks it in reverse.
  function automatic logic [1:0] phase_up(input logic [1:0] p);
    case (p)
      2'd0:    return 2'd2;
      2'd2:    return 2'd1;
      2'd1:    return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic [1:0] phase_dn(input logic [1:0] p);
    case (p)
      2'd0:    return 2'd3;
      2'd2:    return 2'd0;
      2'd1:    return 2'd2;
      default: return 2'd1;
    endcase
  endfunction

  function automatic logic [HT_W-1:0] clamp_step(input logic [HT_W-1:0] ht,
                                                 input logic up, input logic dn);
    if (up && (ht < HT_MAX_V))      return ht + 1'b1;
    else if (dn && (ht > HT_MIN_V)) return ht - 1'b1;
    else                            return ht;
  endfunction

  logic [1:0]       stp_q;
  logic             act_q, dc_q;
  logic [HT_W-1:0]  half_track_q, half_track_d;
  logic [5:0]       track_q, track_d;
  logic             head_side_q, head_side_d;
  logic [SET_W-1:0] settle_q, settle_d;
  logic             dirty_q, dirty_d;
  logic             save_req_q, save_req_d;
  logic [5:0]       save_track_q, save_track_d;
  logic             save_side_q, save_side_d;
  logic             overrun_q, overrun_d;
  logic [CHG_W-1:0] timer_q, timer_d;
  logic             ch_state_q, ch_state_d;

  logic step_up, step_dn, side_evt, act_fall, flush, dc_rise, overrun_set;

  always_comb begin
    step_up      = mtr && (stp == phase_up(stp_q));
    step_dn      = mtr && (stp == phase_dn(stp_q));
    side_evt     = (SIDES == 2) && (side != head_side_q);
    act_fall     = act_q && !act;
    flush        = step_up || step_dn || side_evt || act_fall;
    dc_rise      = disk_change && !dc_q;

    half_track_d = clamp_step(half_track_q, step_up, step_dn);
    track_d      = 6'(half_track_q >> 1);
    head_side_d  = (SIDES == 2) ? side : 1'b0;

    if ((half_track_d != half_track_q) || (head_side_d != head_side_q))
      settle_d = SET_W'(SETTLE_CYC);
    else if (settle_q != '0)
      settle_d = settle_q - 1'b1;
    else
      settle_d = settle_q;

    // A write landing with the flush belongs to the new position, so it keeps dirty set.
    if (disk_change)  dirty_d = 1'b0;
    else if (buff_we) dirty_d = 1'b1;
    else if (flush)   dirty_d = 1'b0;
    else              dirty_d = dirty_q;

    save_req_d   = save_req_q;
    save_track_d = save_track_q;
    save_side_d  = save_side_q;
    overrun_set  = 1'b0;
    if (flush && dirty_q) begin
      if (!save_req_q || save_ack) begin
        save_req_d   = 1'b1;
        save_track_d = track_q;
        save_side_d  = head_side_q;
      end else begin
        overrun_set  = 1'b1;
      end
    end else if (save_ack && save_req_q) begin
      save_req_d = 1'b0;
    end
    overrun_d = dc_rise ? 1'b0 : (overrun_q || overrun_set);

    if (dc_rise)              timer_d = CHG_W'(CHG_CYC);
    else if (timer_q != '0)   timer_d = timer_q - 1'b1;
    else                      timer_d = timer_q;
    ch_state_d = (timer_q != '0);
  end

  always_ff @(posedge clk32 or negedge reset_n) begin
    if (!reset_n) begin
      stp_q        <= 2'd0;
      act_q        <= 1'b0;
      dc_q         <= 1'b0;
      half_track_q <= HT_INIT_V;
      track_q      <= 6'(HT_INIT_V >> 1);
      head_side_q  <= 1'b0;
      settle_q     <= '0;
      dirty_q      <= 1'b0;
      save_req_q   <= 1'b0;
      save_track_q <= 6'd0;
      save_side_q  <= 1'b0;
      overrun_q    <= 1'b0;
      timer_q      <= '0;
      ch_state_q   <= 1'b0;
    end else begin
      stp_q        <= stp;
      act_q        <= act;
      dc_q         <= disk_change;
      half_track_q <= half_track_d;
      track_q      <= track_d;
      head_side_q  <= head_side_d;
      settle_q     <= settle_d;
      dirty_q      <= dirty_d;
      save_req_q   <= save_req_d;
      save_track_q <= save_track_d;
      save_side_q  <= save_side_d;
      overrun_q    <= overrun_d;
      timer_q      <= timer_d;
      ch_state_q   <= ch_state_d;
    end
  end

  assign half_track    = half_track_q;
  assign track         = track_q;
  assign head_side     = head_side_q;
  assign tr00_sense_n  = |track_q;
  assign wps_n         = ~disk_readonly ^ ch_state_q;
  assign track_settled = (settle_q == '0);
  assign save_req      = save_req_q;
  assign save_track    = save_track_q;
  assign save_side     = save_side_q;
  assign save_overrun  = overrun_q;

endmodule

// File: tb/tb_c1541_head_ctrl.sv
// Self-checking bench: single-sided instance plus a double-sided instance with settle delay.
module tb_c1541_head_ctrl;
  logic clk32 = 1'b0;
  logic reset_n, mtr, side, act, buff_we, disk_change, disk_readonly, save_ack;
  logic [1:0] stp;

  logic [6:0] half_track, half_track_b;
  logic [5:0] track, track_b, save_track, save_track_b;
  logic head_side, tr00_sense_n, wps_n, track_settled, save_req, save_side, save_overrun;
  logic head_side_b, tr00_sense_n_b, wps_n_b, track_settled_b, save_req_b, save_side_b, save_overrun_b;

  int checks = 0;
  int errors = 0;
  int ht_m;
  logic [5:0] trk_q[$];
  logic [5:0] exp_trk;

  always #5 clk32 = ~clk32;

  c1541_head_ctrl #(.HT_W(7), .HT_MIN(1), .HT_MAX(80), .HT_INIT(36), .SIDES(1),
                    .SETTLE_CYC(0), .CHG_CYC(100)) dut (
    .clk32(clk32), .reset_n(reset_n), .mtr(mtr), .stp(stp), .side(side), .act(act),
    .buff_we(buff_we), .disk_change(disk_change), .disk_readonly(disk_readonly),
    .half_track(half_track), .track(track), .head_side(head_side), .tr00_sense_n(tr00_sense_n),
    .wps_n(wps_n), .track_settled(track_settled), .save_req(save_req), .save_track(save_track),
    .save_side(save_side), .save_ack(save_ack), .save_overrun(save_overrun));

  c1541_head_ctrl #(.HT_W(7), .HT_MIN(1), .HT_MAX(80), .HT_INIT(36), .SIDES(2),
                    .SETTLE_CYC(8), .CHG_CYC(100)) dut_b (
    .clk32(clk32), .reset_n(reset_n), .mtr(mtr), .stp(stp), .side(side), .act(act),
    .buff_we(buff_we), .disk_change(disk_change), .disk_readonly(disk_readonly),
    .half_track(half_track_b), .track(track_b), .head_side(head_side_b), .tr00_sense_n(tr00_sense_n_b),
    .wps_n(wps_n_b), .track_settled(track_settled_b), .save_req(save_req_b), .save_track(save_track_b),
    .save_side(save_side_b), .save_ack(save_ack), .save_overrun(save_overrun_b));

  task automatic tick;
    @(posedge clk32);
    #1;
  endtask

  task automatic do_reset;
    reset_n = 1'b0; mtr = 1'b0; stp = 2'd0; side = 1'b0; act = 1'b0; buff_we = 1'b0;
    disk_change = 1'b0; disk_readonly = 1'b0; save_ack = 1'b0;
    tick; tick;
    reset_n = 1'b1;
    tick;
    ht_m = 36;
    trk_q.delete();
  endtask

  // Drive one stepper phase change; the head position moves on the following edge.
  task automatic step(input bit up);
    logic [1:0] up_tbl [4];
    logic [1:0] dn_tbl [4];
    up_tbl = '{2'd2, 2'd3, 2'd1, 2'd0};
    dn_tbl = '{2'd3, 2'd2, 2'd0, 2'd1};
    stp = up ? up_tbl[stp] : dn_tbl[stp];
    tick;
    if (up && ht_m < 80) ht_m++;
    else if (!up && ht_m > 1) ht_m--;
  endtask

  task automatic test_reset;
    do_reset;
    checks++; if ({half_track, track} !== {7'd36, 6'd18}) begin errors++; $display("FAIL reset_pos: got ht=%0d trk=%0d want ht=36 trk=18", half_track, track); end
    checks++; if ({head_side, track_settled, tr00_sense_n, wps_n} !== 4'b0111) begin errors++; $display("FAIL reset_flags: got %b want 0111", {head_side, track_settled, tr00_sense_n, wps_n}); end
    checks++; if ({save_req, save_track, save_side, save_overrun} !== 9'd0) begin errors++; $display("FAIL reset_save: got %h want 0", {save_req, save_track, save_side, save_overrun}); end
    checks++; if ({half_track_b, track_b, head_side_b, track_settled_b, tr00_sense_n_b, wps_n_b} !== {7'd36, 6'd18, 4'b0111}) begin errors++; $display("FAIL reset_pos_b: got %h want %h", {half_track_b, track_b, head_side_b, track_settled_b, tr00_sense_n_b, wps_n_b}, {7'd36, 6'd18, 4'b0111}); end
    checks++; if ({save_req_b, save_track_b, save_side_b, save_overrun_b} !== 9'd0) begin errors++; $display("FAIL reset_save_b: got %h want 0", {save_req_b, save_track_b, save_side_b, save_overrun_b}); end
  endtask

  task automatic test_step;
    logic [5:0] old_trk;
    do_reset;
    mtr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      old_trk = 6'(ht_m >> 1);
      step(1'b1);
      checks++; if (half_track !== 7'(ht_m)) begin errors++; $display("FAIL step_ht%0d: got %0d want %0d", i, half_track, ht_m); end
      checks++; if (track !== old_trk) begin errors++; $display("FAIL step_trk_lag%0d: got %0d want %0d", i, track, old_trk); end
      tick;
      checks++; if (track !== 6'(ht_m >> 1)) begin errors++; $display("FAIL step_trk%0d: got %0d want %0d", i, track, ht_m >> 1); end
    end
    checks++; if (half_track !== 7'd39) begin errors++; $display("FAIL step_final: got %0d want 39", half_track); end
  endtask

  task automatic test_motor_gate;
    mtr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1'b1);
      tick;
    end
    ht_m = 39;
    checks++; if (half_track !== 7'd39) begin errors++; $display("FAIL motor_gate: got %0d want 39", half_track); end
    mtr = 1'b1;
    tick;
    checks++; if (half_track !== 7'd39) begin errors++; $display("FAIL motor_resume: got %0d want 39", half_track); end
  endtask

  task automatic test_clamp;
    do_reset;
    mtr = 1'b1;
    for (int i = 0; i < 90; i++) begin step(1'b1); tick; end
    checks++; if ({half_track, track} !== {7'd80, 6'd40}) begin errors++; $display("FAIL clamp_top: got ht=%0d trk=%0d want ht=80 trk=40", half_track, track); end
    checks++; if (tr00_sense_n !== 1'b1) begin errors++; $display("FAIL clamp_top_tr00: got %b want 1", tr00_sense_n); end
    for (int i = 0; i < 100; i++) begin step(1'b0); tick; end
    checks++; if ({half_track, track} !== {7'd1, 6'd0}) begin errors++; $display("FAIL clamp_floor: got ht=%0d trk=%0d want ht=1 trk=0", half_track, track); end
    checks++; if (tr00_sense_n !== 1'b0) begin errors++; $display("FAIL clamp_tr00: got %b want 0", tr00_sense_n); end
  endtask

  task automatic test_dirty_flush;
    do_reset;
    mtr = 1'b1;
    buff_we = 1'b1; tick; buff_we = 1'b0;
    trk_q.push_back(6'(ht_m >> 1));
    step(1'b1);
    checks++;
    if (save_req !== 1'b1) begin
      errors++; $display("FAIL flush_req: got %b want 1", save_req);
    end else begin
      exp_trk = trk_q.pop_front();
      checks++; if ({save_track, save_side} !== {exp_trk, 1'b0}) begin errors++; $display("FAIL flush_trk: got trk=%0d side=%b want trk=%0d side=0", save_track, save_side, exp_trk); end
    end
    for (int i = 0; i < 10; i++) begin
      tick;
      checks++; if ({save_req, save_track} !== {1'b1, 6'd18}) begin errors++; $display("FAIL flush_hold%0d: got req=%b trk=%0d want req=1 trk=18", i, save_req, save_track); end
    end
    save_ack = 1'b1; tick; save_ack = 1'b0;
    checks++; if (save_req !== 1'b0) begin errors++; $display("FAIL flush_drop: got %b want 0", save_req); end
  endtask

  task automatic test_overrun;
    do_reset;
    mtr = 1'b1;
    buff_we = 1'b1; tick; buff_we = 1'b0;
    trk_q.push_back(6'(ht_m >> 1));
    step(1'b1); tick;
    checks++;
    if (save_req !== 1'b1) begin
      errors++; $display("FAIL ovr_req: got %b want 1", save_req);
    end else begin
      exp_trk = trk_q.pop_front();
      checks++; if (save_track !== exp_trk) begin errors++; $display("FAIL ovr_first: got %0d want %0d", save_track, exp_trk); end
    end
    buff_we = 1'b1; tick; buff_we = 1'b0;
    step(1'b1); tick;
    checks++; if ({save_req, save_track, save_overrun} !== {1'b1, 6'd18, 1'b1}) begin errors++; $display("FAIL ovr_set: got req=%b trk=%0d ovr=%b want req=1 trk=18 ovr=1", save_req, save_track, save_overrun); end
    disk_change = 1'b1; tick;
    checks++; if (save_overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %b want 0", save_overrun); end
    disk_change = 1'b0;
    step(1'b1); tick;
    checks++; if ({save_req, save_overrun} !== 2'b10) begin errors++; $display("FAIL ovr_clean_step: got req=%b ovr=%b want req=1 ovr=0", save_req, save_overrun); end
    save_ack = 1'b1; tick; save_ack = 1'b0;
  endtask

  task automatic test_simultaneous;
    do_reset;
    mtr = 1'b1;
    buff_we = 1'b1; tick; buff_we = 1'b0;
    trk_q.push_back(6'(ht_m >> 1));
    step(1'b1); tick;
    exp_trk = trk_q.pop_front();
    checks++; if ({save_req, save_track} !== {1'b1, exp_trk}) begin errors++; $display("FAIL sim_first: got req=%b trk=%0d want req=1 trk=%0d", save_req, save_track, exp_trk); end
    step(1'b1); tick;
    buff_we = 1'b1; tick; buff_we = 1'b0;
    trk_q.push_back(6'(ht_m >> 1));
    save_ack = 1'b1;
    step(1'b1);
    save_ack = 1'b0;
    exp_trk = trk_q.pop_front();
    checks++; if ({save_req, save_track} !== {1'b1, exp_trk}) begin errors++; $display("FAIL sim_ack_flush: got req=%b trk=%0d want req=1 trk=%0d", save_req, save_track, exp_trk); end
    save_ack = 1'b1; tick; save_ack = 1'b0;
    buff_we = 1'b1;
    step(1'b0);
    buff_we = 1'b0;
    checks++; if (save_req !== 1'b0) begin errors++; $display("FAIL sim_we_step_req: got %b want 0", save_req); end
    tick;
    trk_q.push_back(6'(ht_m >> 1));
    act = 1'b1; tick; act = 1'b0; tick;
    checks++;
    if (save_req !== 1'b1) begin
      errors++; $display("FAIL sim_we_step_dirty: got req=%b want 1", save_req);
    end else begin
      exp_trk = trk_q.pop_front();
      checks++; if (save_track !== exp_trk) begin errors++; $display("FAIL sim_act_trk: got %0d want %0d", save_track, exp_trk); end
    end
    save_ack = 1'b1; tick; save_ack = 1'b0;
    act = 1'b1; tick; act = 1'b0; tick;
    checks++; if ({save_req, save_overrun} !== 2'b00) begin errors++; $display("FAIL sim_clean_act: got req=%b ovr=%b want 00", save_req, save_overrun); end
  endtask

  task automatic test_flicker;
    int low_cnt;
    do_reset;
    disk_readonly = 1'b1; tick;
    checks++; if (wps_n !== 1'b0) begin errors++; $display("FAIL wps_ro: got %b want 0", wps_n); end
    disk_readonly = 1'b0;
    disk_change = 1'b1; tick;
    low_cnt = 0;
    for (int i = 0; i < 200; i++) begin
      tick;
      if (wps_n === 1'b0) low_cnt++;
    end
    checks++; if (low_cnt !== 100) begin errors++; $display("FAIL wps_flicker_len: got %0d want 100", low_cnt); end
    checks++; if (wps_n !== 1'b1) begin errors++; $display("FAIL wps_after: got %b want 1", wps_n); end
    disk_change = 1'b0; tick;
  endtask

  task automatic test_sides;
    int low_cnt;
    do_reset;
    mtr = 1'b1;
    buff_we = 1'b1; tick; buff_we = 1'b0;
    trk_q.push_back(6'd18);
    side = 1'b1; tick;
    checks++;
    if (save_req_b !== 1'b1) begin
      errors++; $display("FAIL side_req: got %b want 1", save_req_b);
    end else begin
      exp_trk = trk_q.pop_front();
      checks++; if ({save_track_b, save_side_b, head_side_b} !== {exp_trk, 1'b0, 1'b1}) begin errors++; $display("FAIL side_latch: got trk=%0d sside=%b head=%b want trk=%0d sside=0 head=1", save_track_b, save_side_b, head_side_b, exp_trk); end
    end
    checks++; if ({head_side, save_req} !== 2'b00) begin errors++; $display("FAIL side_single: got head=%b req=%b want 00", head_side, save_req); end
    low_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (track_settled_b === 1'b0) low_cnt++;
      tick;
    end
    checks++; if (low_cnt !== 8) begin errors++; $display("FAIL side_settle: got %0d want 8", low_cnt); end
  endtask

  task automatic test_reset_mid;
    do_reset;
    mtr = 1'b1;
    buff_we = 1'b1; tick; buff_we = 1'b0;
    step(1'b1);
    checks++; if (save_req !== 1'b1) begin errors++; $display("FAIL rstmid_pre: got %b want 1", save_req); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if ({save_req, save_track, half_track} !== {1'b0, 6'd0, 7'd36}) begin errors++; $display("FAIL rstmid_async: got req=%b trk=%0d ht=%0d want 0/0/36", save_req, save_track, half_track); end
    tick;
    reset_n = 1'b1;
    tick; tick;
    checks++; if (save_req !== 1'b0) begin errors++; $display("FAIL rstmid_after: got %b want 0", save_req); end
  endtask

  initial begin
    test_reset;
    test_step;
    test_motor_gate;
    test_clamp;
    test_dirty_flush;
    test_overrun;
    test_simultaneous;
    test_flicker;
    test_sides;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
